// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first.
// Result, carry and signed overflow are registered when the last bit is summed.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0] part, part_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_c;
  logic             last;

  assign fa_s = sa[0] ^ sb[0] ^ carry;
  assign fa_c = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
  assign last = (cnt == LAST);

  // New sum bit enters at the MSB so the result is aligned after WIDTH shifts
  if (WIDTH == 1) begin : g_one
    assign part_nx = fa_s;
  end else begin : g_multi
    assign part_nx = {fa_s, part[WIDTH-1:1]};
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sa    <= '0;
      sb    <= '0;
      part  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      sa    <= op_a;
      sb    <= op_b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      part  <= part_nx;
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= part_nx;
        cout <= fa_c;
        ovf  <= carry ^ fa_c;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
